// File: rtl/alu_lock_arbiter.sv
// Grants the single shared ALU to the oldest requesting SIC and steers its operands/result.
// Latency: grant one cycle after req is sampled; zero-bubble handoff on owner release.
// Backpressure: a requester simply holds req until granted; the owner holds the lock until release.
module alu_lock_arbiter #(
   parameter  int NUM_SICS = 4,
   parameter  int ID_WIDTH = 6,
   localparam int OWNER_W  = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_SICS-1:0]                req,
   input  logic [NUM_SICS-1:0][ID_WIDTH-1:0]  req_issue_id,
   input  logic [NUM_SICS-1:0]                release_lock,
   input  logic [NUM_SICS-1:0][5:0]           sic_op,
   input  logic [NUM_SICS-1:0][31:0]          sic_a,
   input  logic [NUM_SICS-1:0][31:0]          sic_b,
   output logic [NUM_SICS-1:0]                grant,
   output logic [5:0]                         alu_op,
   output logic [31:0]                        alu_a,
   output logic [31:0]                        alu_b,
   input  logic [31:0]                        alu_c,
   input  logic                               alu_zero,
   output logic [31:0]                        ans_c,
   output logic                               ans_zero,
   output logic                               locked,
   output logic [OWNER_W-1:0]                 owner
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [OWNER_W-1:0]   owner_q, owner_d;
   logic [NUM_SICS-1:0]  cand;

   // Oldest candidate by wrapping issue id: a is older than b when (a - b)
   // is negative as a signed ID_WIDTH value. Scanning upward and replacing
   // only on strictly-older gives equal ids to the lowest index.
   function automatic logic [OWNER_W-1:0] pick_oldest(
      input logic [NUM_SICS-1:0]               c,
      input logic [NUM_SICS-1:0][ID_WIDTH-1:0] ids
   );
      logic                found;
      logic [OWNER_W-1:0]  best;
      logic [ID_WIDTH-1:0] best_id;
      logic [ID_WIDTH-1:0] diff;
      found   = 1'b0;
      best    = '0;
      best_id = '0;
      for (int i = 0; i < NUM_SICS; i++) begin
         diff = ids[i] - best_id;
         if (c[i] && (!found || diff[ID_WIDTH-1])) begin
            found   = 1'b1;
            best    = OWNER_W'(i);
            best_id = ids[i];
         end
      end
      return best;
   endfunction

   // State and owner registers; reset drops any held lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Next-state: acquire from idle, or hand off to the oldest other requester
   // on the owner's release. Non-owner releases and younger requests are ignored.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cand    = req;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_LOCKED;
               owner_d = pick_oldest(req, req_issue_id);
            end
         end
         S_LOCKED: begin
            if (release_lock[owner_q]) begin
               cand[owner_q] = 1'b0;
               if (|cand) begin
                  owner_d = pick_oldest(cand, req_issue_id);
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Grant decode and operand steering come from registered state only;
   // operands themselves pass through combinationally from the owner.
   always_comb begin
      grant  = '0;
      alu_op = '0;
      alu_a  = '0;
      alu_b  = '0;
      if (state_q == S_LOCKED) begin
         grant[owner_q] = 1'b1;
         alu_op         = sic_op[owner_q];
         alu_a          = sic_a[owner_q];
         alu_b          = sic_b[owner_q];
      end
   end

   // Result is broadcast unconditionally; only the granted SIC consumes it.
   assign ans_c    = alu_c;
   assign ans_zero = alu_zero;
   assign locked   = (state_q == S_LOCKED);
   assign owner    = owner_q;

endmodule
